// File: rtl/register_bank_cleared.sv
// Two-read, one-write register bank with write-to-read forwarding and a post-reset clear sweep.
// Optional macro REGISTER_BANK_ZERO_PROTECT_EN makes entry 0 a hard-wired zero register.
module register_bank_cleared #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     busy,
  input  logic [ADDRESS_WIDTH-1:0] readIndex1,
  output logic [DATA_WIDTH-1:0]    readData1,
  input  logic [ADDRESS_WIDTH-1:0] readIndex2,
  output logic [DATA_WIDTH-1:0]    readData2,
  input  logic [ADDRESS_WIDTH-1:0] writeIndex,
  input  logic [DATA_WIDTH-1:0]    writeData,
  input  logic                     writeEnable
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] LastIdx = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e                   r_state;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic                     r_busy;
  logic [DATA_WIDTH-1:0]    r_rd1;
  logic [DATA_WIDTH-1:0]    r_rd2;
  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];

  logic                     w_mem_we;
  logic [ADDRESS_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0]    w_mem_wdata;
  logic                     w_wr_zero;
  logic                     w_rd1_zero;
  logic                     w_rd2_zero;
  logic                     w_fwd1;
  logic                     w_fwd2;

`ifdef REGISTER_BANK_ZERO_PROTECT_EN
  assign w_wr_zero  = (writeIndex == '0);
  assign w_rd1_zero = (readIndex1 == '0);
  assign w_rd2_zero = (readIndex2 == '0);
`else
  assign w_wr_zero  = 1'b0;
  assign w_rd1_zero = 1'b0;
  assign w_rd2_zero = 1'b0;
`endif

  assign w_fwd1 = writeEnable && (writeIndex == readIndex1);
  assign w_fwd2 = writeEnable && (writeIndex == readIndex2);

  // Single write port shared between the clear sweep and normal writes; idle in the reset cycle.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = writeIndex;
    w_mem_wdata = writeData;
    if (!reset) begin
      unique case (r_state)
        StClear: begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_count[ADDRESS_WIDTH-1:0];
          w_mem_wdata = '0;
        end
        StReady: w_mem_we = writeEnable && !w_wr_zero;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StClear;
      r_count <= '0;
      r_busy  <= 1'b1;
      r_rd1   <= '0;
      r_rd2   <= '0;
    end else begin
      unique case (r_state)
        StClear: begin
          r_count <= r_count + (ADDRESS_WIDTH + 1)'(1);
          r_rd1   <= '0;
          r_rd2   <= '0;
          if (r_count == LastIdx) begin
            r_state <= StReady;
            r_busy  <= 1'b0;
          end
        end
        StReady: begin
          if (w_rd1_zero)  r_rd1 <= '0;
          else if (w_fwd1) r_rd1 <= writeData;
          else             r_rd1 <= r_mem[readIndex1];
          if (w_rd2_zero)  r_rd2 <= '0;
          else if (w_fwd2) r_rd2 <= writeData;
          else             r_rd2 <= r_mem[readIndex2];
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign readData1 = r_rd1;
  assign readData2 = r_rd2;

endmodule

// File: tb/tb_register_bank_cleared.sv
// Scoreboard bench for register_bank_cleared: stimulus queues expected read data, monitor compares.
// Honours REGISTER_BANK_ZERO_PROTECT_EN for the entry-0 expectations.
module tb_register_bank_cleared;

  localparam int AW = 5;
  localparam int DW = 32;

`ifdef REGISTER_BANK_ZERO_PROTECT_EN
  localparam logic [DW-1:0] ZeroExp = 32'h0000_0000;
`else
  localparam logic [DW-1:0] ZeroExp = 32'h1234_5678;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          busy;
  logic [AW-1:0] readIndex1;
  logic [DW-1:0] readData1;
  logic [AW-1:0] readIndex2;
  logic [DW-1:0] readData2;
  logic [AW-1:0] writeIndex;
  logic [DW-1:0] writeData;
  logic          writeEnable;

  register_bank_cleared #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .busy       (busy),
    .readIndex1 (readIndex1),
    .readData1  (readData1),
    .readIndex2 (readIndex2),
    .readData2  (readData2),
    .writeIndex (writeIndex),
    .writeData  (writeData),
    .writeEnable(writeEnable)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    int            id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   id_ctr = 0;
  logic req = 1'b0;
  logic valid_q = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // A read issued at posedge t is visible from t+1; compare at the following negedge.
  always @(posedge clock) valid_q <= req;

  always @(negedge clock) begin
    if (valid_q) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("rd1_%0d", e.id), readData1, e.e1);
        check($sformatf("rd2_%0d", e.id), readData2, e.e2);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input bit we, input logic [AW-1:0] wi, input logic [DW-1:0] wd,
                    input bit rd, input logic [AW-1:0] i1, input logic [AW-1:0] i2,
                    input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    writeEnable = we;
    writeIndex  = wi;
    writeData   = wd;
    readIndex1  = i1;
    readIndex2  = i2;
    req         = rd;
    if (rd) begin
      e.e1 = e1;
      e.e2 = e2;
      e.id = id_ctr++;
      sb.push_back(e);
    end
    tick();
    writeEnable = 1'b0;
    req         = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    writeEnable = 1'b0;
    check({name, "_len"}, n, 32);
    check({name, "_busy_low"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    readIndex1  = '0;
    readIndex2  = '0;
    writeIndex  = '0;
    writeData   = '0;
    writeEnable = 1'b0;
    tick();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_rd1", readData1, 32'd0);
    check("reset_rd2", readData2, 32'd0);

    // Sweep with a write attempt to entry 5 held the whole time.
    reset       = 1'b0;
    writeEnable = 1'b1;
    writeIndex  = 5;
    writeData   = 32'hAAAA_5555;
    readIndex1  = 5;
    readIndex2  = 5;
    wait_sweep("sweep1");
    check("sweep_rd1_zero", readData1, 32'd0);

    for (int i = 0; i < 32; i++) begin
      op(1'b0, '0, '0, 1'b1, AW'(i), AW'(31 - i), 32'd0, 32'd0);
    end

    op(1'b1, 7, 32'hDEAD_BEEF, 1'b0, '0, '0, '0, '0);
    op(1'b0, '0, '0, 1'b1, 7, 8, 32'hDEAD_BEEF, 32'd0);

    op(1'b1, 3, 32'h1111_1111, 1'b0, '0, '0, '0, '0);
    op(1'b0, '0, '0, 1'b1, 3, 3, 32'h1111_1111, 32'h1111_1111);
    op(1'b1, 3, 32'h2222_2222, 1'b1, 3, 3, 32'h2222_2222, 32'h2222_2222);
    op(1'b0, '0, '0, 1'b1, 3, 7, 32'h2222_2222, 32'hDEAD_BEEF);

    // Forwarding on one port only.
    op(1'b1, 9, 32'h0000_005A, 1'b1, 9, 7, 32'h0000_005A, 32'hDEAD_BEEF);
    op(1'b1, 10, 32'hCAFE_F00D, 1'b1, 9, 10, 32'h0000_005A, 32'hCAFE_F00D);

    op(1'b1, 0, 32'h1234_5678, 1'b1, 0, 0, ZeroExp, ZeroExp);
    op(1'b0, '0, '0, 1'b1, 0, 4, ZeroExp, 32'd0);

    // Reset mid-sweep restarts the full sweep.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_busy_reset", {31'b0, busy}, 32'd1);
    check("mid_rd1_reset", readData1, 32'd0);
    reset = 1'b0;
    wait_sweep("sweep2");
    op(1'b0, '0, '0, 1'b1, 7, 3, 32'd0, 32'd0);
    op(1'b0, '0, '0, 1'b1, 0, 9, 32'd0, 32'd0);

    repeat (3) tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_cleared.md
Name: register_bank_cleared

Overview:
Parametrised successor to the CPU general-purpose register file: DEPTH x DATA_WIDTH memory with two synchronous read ports and one independent synchronous write port.
- Write-to-read forwarding on both read ports.
- Self-clearing sweep after reset that zeroes every entry, with a busy flag so the pipeline stalls until the registers are defined.
- Sits in the CPU datapath between decode (indices) and execute/writeback; storage is block-RAM mappable.

Parameters:
DATA_WIDTH, 32, bits per register
ADDRESS_WIDTH, 5, index width; DEPTH = 2**ADDRESS_WIDTH entries

Ports:
clock  input  1  the clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
busy  output  1  high while the clear sweep runs; accesses ignored
readIndex1  input  ADDRESS_WIDTH  read port 1 index
readData1  output  DATA_WIDTH  read port 1 data, registered
readIndex2  input  ADDRESS_WIDTH  read port 2 index
readData2  output  DATA_WIDTH  read port 2 data, registered
writeIndex  input  ADDRESS_WIDTH  write port index
writeData  input  DATA_WIDTH  write data
writeEnable  input  1  write strobe, sampled at posedge

Behaviour:
Interface
- One clock (clock).
- Reset is synchronous and active-high (reset).

Reset
- Any posedge with reset=1 sets state=CLEAR, sweep counter=0, busy=1, readData1=readData2=0.
- Memory contents are not touched in the reset cycle itself.

State CLEAR (reset=0)
- Each posedge writes 0 to entry[counter], then counter+1.
- On the posedge that writes entry DEPTH-1: state -> READY, busy -> 0 from the next cycle on.
- The sweep therefore takes exactly DEPTH cycles after reset deasserts.
- writeEnable is ignored; readData1/2 stay 0.
- Reset asserted mid-sweep restarts the sweep from counter=0.

State READY
Reads
- Latency 1: readDataN at cycle t+1 reflects readIndexN at posedge t.
Write
- If writeEnable=1, entry[writeIndex] <= writeData at the posedge.
Forwarding
- If writeEnable=1 and writeIndex==readIndexN at the same posedge, readDataN <= writeData (new data), not the old entry.
- This applies independently to each port.
- Both ports may read the same index; both get the same value.
- Read-only cycles never modify memory.

Other rules
- The counter is ADDRESS_WIDTH+1 bits or an explicit terminal compare; no wrap back into CLEAR.
- Entry 0 is an ordinary register unless the optional feature is compiled in.
- No X on outputs at any time after the first reset cycle.

Optional Feature:
Macro: REGISTER_BANK_ZERO_PROTECT_EN
- Defined:
  - Writes with writeIndex==0 are discarded; entry 0 stays 0.
  - No forwarding occurs for index 0; reads of index 0 always return 0.
- Undefined: entry 0 behaves like every other entry, and callers must protect it.

Test Plan:
1. Reset sweep: pulse reset 1 cycle, hold reset=0 -> busy=1 for exactly 32 cycles (default params) then 0; then reading indices 0..31 on both ports returns 0.
2. Write/read: after the sweep, write 0xDEADBEEF to index 7, next cycle readIndex1=7 -> readData1=0xDEADBEEF one cycle later; readIndex2=8 -> 0.
3. Forwarding: entry 3 holds 0x11111111; same posedge writeIndex=3, writeData=0x22222222, readIndex1=readIndex2=3 -> both outputs 0x22222222 next cycle.
4. Ignored writes while busy: write 0xAAAA5555 to index 5 during the sweep -> after busy falls, index 5 reads 0.
5. Reset mid-sweep: assert reset at sweep cycle 10 -> busy stays 1, and the sweep again takes the full 32 cycles from reset deassertion.
6. Zero-register protection:
   - With REGISTER_BANK_ZERO_PROTECT_EN: write 0x12345678 to index 0 -> reads of index 0 return 0, including the same-cycle forwarding case.
   - Without the macro: the same write reads back 0x12345678.
